// File: rtl/fb_pkg.sv
// Shared states, RGB565 field positions and default frame geometry for the LCD frame-buffer fetch path.
// Pure declarations: no timing or flow-control behaviour of its own.
package fb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    REQ       = 3'd2,
    WAIT_DATA = 3'd3,
    PUSH      = 3'd4
  } fb_state_e;

  localparam int FB_WIDTH         = 640;
  localparam int FB_HEIGHT        = 480;
  localparam int FB_WORDS_DEFAULT = FB_WIDTH * FB_HEIGHT;
  localparam int WORD_CNT_W       = 19;

  // RGB565 packing: RRRRRGGGGGGBBBBB
  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  localparam int TMO_MIN_W = 8;

  // Watchdog counter width: enough to reach the limit, never below 8 bits.
  function automatic int tmo_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w > TMO_MIN_W) ? w : TMO_MIN_W;
  endfunction

endpackage

// File: rtl/rgb565_to_888.sv
// Combinational RGB565 -> RGB888 expander; zero latency, no flow control.
// Each channel's MSBs are replicated into its new LSBs so full scale maps to 8'hFF.
module rgb565_to_888
  import fb_pkg::*;
(
  input  logic [15:0] rgb565_i,
  output logic [23:0] rgb888_o
);

  logic [4:0] r5;
  logic [5:0] g6;
  logic [4:0] b5;

  assign r5 = rgb565_i[R5_MSB:R5_LSB];
  assign g6 = rgb565_i[G6_MSB:G6_LSB];
  assign b5 = rgb565_i[B5_MSB:B5_LSB];

  assign rgb888_o = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

endmodule

// File: rtl/fb_prefetch.sv
// Frame-buffer fetch: sequential SDRAM RGB565 reads expanded into RGB888 pixel FIFO writes, >= 3 cycles + read latency per word.
// Stalls in PUSH while fifo_full (no new reads); `FB_TIMEOUT_EN adds a read watchdog that writes black and sets sticky err.
module fb_prefetch
  import fb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 16,
  parameter int FB_BASE        = 0,
  parameter int FB_WORDS       = FB_WORDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  input  logic                  busy,
  output logic [23:0]           fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  frame_done,
  output logic                  err
);

  if (DATA_WIDTH != 16) begin : g_bad_data_width
    $error("fb_prefetch: DATA_WIDTH must be 16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fb_prefetch: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(FB_BASE);
  localparam logic [WORD_CNT_W-1:0] LAST_CNT  = WORD_CNT_W'(FB_WORDS - 1);

  fb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]           hold_q, hold_d;
  logic                  restart_pend_q, restart_pend_d;
  logic                  rd_enable_q, rd_enable_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [23:0]           fifo_din_q, fifo_din_d;
  logic                  last_push_q, last_push_d;
  logic                  frame_done_q, frame_done_d;
  logic [23:0]           pix888;
  logic                  tmo_hit;
  logic                  do_restart;

  rgb565_to_888 u_expand (
    .rgb565_i (hold_q),
    .rgb888_o (pix888)
  );

  always_comb begin
    state_d        = state_q;
    rd_addr_d      = rd_addr_q;
    word_cnt_d     = word_cnt_q;
    hold_d         = hold_q;
    restart_pend_d = restart_pend_q;
    rd_enable_d    = 1'b0;
    fifo_wr_en_d   = 1'b0;
    fifo_din_d     = fifo_din_q;
    last_push_d    = 1'b0;
    frame_done_d   = last_push_q;
    do_restart     = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          do_restart = 1'b1;
        end
      end

      FETCH: begin
        if (frame_start) begin
          do_restart = 1'b1;
        end else if (enable) begin
          rd_enable_d = 1'b1;
          state_d     = REQ;
        end
      end

      // The controller handshake is never abandoned; a restart here is deferred.
      REQ: begin
        if (frame_start) begin
          restart_pend_d = 1'b1;
        end
        if (busy) begin
          state_d = WAIT_DATA;
        end else begin
          rd_enable_d = 1'b1;
        end
      end

      WAIT_DATA: begin
        if (frame_start) begin
          restart_pend_d = 1'b1;
        end
        if (rd_ready || tmo_hit) begin
          if (restart_pend_q || frame_start) begin
            do_restart = 1'b1;
          end else begin
            hold_d  = rd_ready ? rd_data[15:0] : 16'h0000;
            state_d = PUSH;
          end
        end
      end

      PUSH: begin
        if (frame_start) begin
          do_restart = 1'b1;
        end else if (!fifo_full) begin
          fifo_wr_en_d = 1'b1;
          fifo_din_d   = pix888;
          rd_addr_d    = rd_addr_q + ADDR_WIDTH'(1);
          word_cnt_d   = word_cnt_q + WORD_CNT_W'(1);
          if (word_cnt_q == LAST_CNT) begin
            last_push_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Every restart path, including the initial start from IDLE, lands in FETCH at the frame origin.
    if (do_restart) begin
      rd_addr_d      = BASE_ADDR;
      word_cnt_d     = '0;
      restart_pend_d = 1'b0;
      state_d        = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_addr_q      <= BASE_ADDR;
      word_cnt_q     <= '0;
      hold_q         <= '0;
      restart_pend_q <= 1'b0;
      rd_enable_q    <= 1'b0;
      fifo_wr_en_q   <= 1'b0;
      fifo_din_q     <= '0;
      last_push_q    <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      word_cnt_q     <= word_cnt_d;
      hold_q         <= hold_d;
      restart_pend_q <= restart_pend_d;
      rd_enable_q    <= rd_enable_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_din_q     <= fifo_din_d;
      last_push_q    <= last_push_d;
      frame_done_q   <= frame_done_d;
    end
  end

`ifdef FB_TIMEOUT_EN
  localparam int TMO_W = tmo_width(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;

  // Counts cycles spent in WAIT_DATA; clears whenever the state is left.
  always_comb begin
    tmo_cnt_d = '0;
    err_d     = err_q;
    tmo_hit   = 1'b0;
    if (state_q == WAIT_DATA && !rd_ready) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit = 1'b1;
        err_d   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  assign rd_addr    = rd_addr_q;
  assign rd_enable  = rd_enable_q;
  assign fifo_din   = fifo_din_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fb_prefetch.sv
// Bench for fb_prefetch: two instances (base 0 / 4 words, base 100 / 3 words) behind a simple SDRAM read model.
// Expected pixels are queued when a scenario starts and popped as FIFO writes appear.
module tb_fb_prefetch;

  localparam int AW = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable[2];
  logic          frame_start[2];
  logic          fifo_full[2];
  logic [AW-1:0] rd_addr[2];
  logic          rd_enable[2];
  logic [15:0]   rd_data[2];
  logic          rd_ready[2];
  logic          busy[2];
  logic [23:0]   fifo_din[2];
  logic          fifo_wr_en[2];
  logic          frame_done[2];
  logic          err[2];

  int n_cmp = 0;
  int n_bad = 0;
  int lat[2];
  int cnt[2];

  logic [AW-1:0] addr_log0[$];
  logic [AW-1:0] addr_log1[$];
  logic [23:0]   exp_q[$];

  fb_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .FB_BASE(0), .FB_WORDS(4), .TIMEOUT_CYCLES(10)) dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable[0]), .frame_start(frame_start[0]),
    .rd_addr(rd_addr[0]), .rd_enable(rd_enable[0]), .rd_data(rd_data[0]), .rd_ready(rd_ready[0]),
    .busy(busy[0]), .fifo_din(fifo_din[0]), .fifo_wr_en(fifo_wr_en[0]), .fifo_full(fifo_full[0]),
    .frame_done(frame_done[0]), .err(err[0])
  );

  fb_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .FB_BASE(100), .FB_WORDS(3), .TIMEOUT_CYCLES(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable[1]), .frame_start(frame_start[1]),
    .rd_addr(rd_addr[1]), .rd_enable(rd_enable[1]), .rd_data(rd_data[1]), .rd_ready(rd_ready[1]),
    .busy(busy[1]), .fifo_din(fifo_din[1]), .fifo_wr_en(fifo_wr_en[1]), .fifo_full(fifo_full[1]),
    .frame_done(frame_done[1]), .err(err[1])
  );

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    case (a)
      AW'(0):  return 16'hF800;
      AW'(1):  return 16'h07E0;
      AW'(2):  return 16'h001F;
      AW'(3):  return 16'hFFFF;
      default: return a[15:0] ^ 16'h5A3C;
    endcase
  endfunction

  function automatic logic [23:0] exp888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  // Controller model: busy the cycle after a request, data strobe lat cycles after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        busy[i]     <= 1'b0;
        rd_ready[i] <= 1'b0;
        rd_data[i]  <= '0;
        cnt[i]      <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rd_ready[i] <= 1'b0;
        if (cnt[i] > 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) begin
            rd_ready[i] <= 1'b1;
            busy[i]     <= 1'b0;
          end
        end else if (rd_enable[i] && !busy[i]) begin
          busy[i]    <= 1'b1;
          cnt[i]     <= lat[i];
          rd_data[i] <= mem_word(rd_addr[i]);
          if (i == 0) addr_log0.push_back(rd_addr[i]);
          else        addr_log1.push_back(rd_addr[i]);
        end
      end
    end
  end

  task automatic pulse_start(input int idx);
    @(negedge clk);
    frame_start[idx] = 1'b1;
    @(negedge clk);
    frame_start[idx] = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW-1:0] want_base;
    int            n_req;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b1; frame_start[i] = 1'b0; fifo_full[i] = 1'b0; lat[i] = 6;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      want_base = (i == 0) ? AW'(0) : AW'(100);
      n_cmp += 6;
      if (rd_enable[i] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_enable[%0d]: got %b want 0", i, rd_enable[i]); end
      if (rd_addr[i] !== want_base) begin n_bad++; $display("FAIL reset_rd_addr[%0d]: got %0d want %0d", i, rd_addr[i], want_base); end
      if (fifo_wr_en[i] !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_wr_en[%0d]: got %b want 0", i, fifo_wr_en[i]); end
      if (fifo_din[i] !== 24'h0) begin n_bad++; $display("FAIL reset_fifo_din[%0d]: got %h want 000000", i, fifo_din[i]); end
      if (frame_done[i] !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done[%0d]: got %b want 0", i, frame_done[i]); end
      if (err[i] !== 1'b0) begin n_bad++; $display("FAIL reset_err[%0d]: got %b want 0", i, err[i]); end
    end
    rst_n = 1'b1;
    n_req = 0;
    repeat (12) begin
      @(negedge clk);
      if (rd_enable[0] || rd_enable[1]) n_req++;
    end
    n_cmp++;
    if (n_req != 0) begin n_bad++; $display("FAIL idle_no_request: got %0d request cycles want 0", n_req); end
  endtask

  task automatic test_normal_fetch();
    int ndone, last_wr;
    logic [23:0] want;
    exp_q.delete(); addr_log0.delete();
    exp_q.push_back(24'hFF0000); exp_q.push_back(24'h00FF00);
    exp_q.push_back(24'h0000FF); exp_q.push_back(24'hFFFFFF);
    ndone = 0; last_wr = -10;
    pulse_start(0);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (fifo_wr_en[0]) begin
        n_cmp++; last_wr = c;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL normal_extra_write: got %h want no write", fifo_din[0]); end
        else begin
          want = exp_q.pop_front();
          if (fifo_din[0] !== want) begin n_bad++; $display("FAIL normal_data: got %h want %h", fifo_din[0], want); end
        end
      end
      if (frame_done[0]) begin
        ndone++; n_cmp++;
        if (c != last_wr + 1 || exp_q.size() != 0) begin
          n_bad++; $display("FAIL normal_done_timing: got cycle %0d want %0d", c, last_wr + 1);
        end
      end
    end
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL normal_missing: got %0d unwritten want 0", exp_q.size()); end
    if (ndone != 1) begin n_bad++; $display("FAIL normal_done_count: got %0d want 1", ndone); end
    n_cmp++;
    if (addr_log0.size() != 4) begin n_bad++; $display("FAIL normal_addr_count: got %0d want 4", addr_log0.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (addr_log0[k] !== AW'(k)) begin n_bad++; $display("FAIL normal_addr[%0d]: got %0d want %0d", k, addr_log0[k], k); end
    end
  endtask

  task automatic test_full_stall();
    int ndone, viol, t;
    logic [23:0] want;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(exp888(mem_word(AW'(k))));
    fifo_full[0] = 1'b1;
    pulse_start(0);
    t = 0;
    while (rd_ready[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_cmp++;
    if (t >= 100) begin n_bad++; $display("FAIL stall_no_data: got no rd_ready want one within 100 cycles"); end
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (fifo_wr_en[0] || rd_enable[0]) viol++;
    end
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("FAIL stall_activity: got %0d active cycles want 0", viol); end
    fifo_full[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en[0] !== 1'b1) begin n_bad++; $display("FAIL stall_release_write: got %b want 1", fifo_wr_en[0]); end
    else begin
      want = exp_q.pop_front();
      n_cmp++;
      if (fifo_din[0] !== want) begin n_bad++; $display("FAIL stall_release_data: got %h want %h", fifo_din[0], want); end
    end
    ndone = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (fifo_wr_en[0]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL stall_extra_write: got %h want no write", fifo_din[0]); end
        else begin
          want = exp_q.pop_front();
          if (fifo_din[0] !== want) begin n_bad++; $display("FAIL stall_data: got %h want %h", fifo_din[0], want); end
        end
      end
      if (frame_done[0]) ndone++;
    end
    n_cmp += 2;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL stall_missing: got %0d unwritten want 0", exp_q.size()); end
    if (ndone != 1) begin n_bad++; $display("FAIL stall_done_count: got %0d want 1", ndone); end
  endtask

  task automatic test_mid_read_restart();
    int ndone;
    bit restarted, clr;
    logic [23:0] want;
    logic [AW-1:0] want_addr[7];
    want_addr = '{AW'(0), AW'(1), AW'(2), AW'(0), AW'(1), AW'(2), AW'(3)};
    exp_q.delete(); addr_log0.delete();
    exp_q.push_back(exp888(mem_word(AW'(0)))); exp_q.push_back(exp888(mem_word(AW'(1))));
    for (int k = 0; k < 4; k++) exp_q.push_back(exp888(mem_word(AW'(k))));
    ndone = 0; restarted = 0; clr = 0;
    pulse_start(0);
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (clr) begin frame_start[0] = 1'b0; clr = 0; end
      if (fifo_wr_en[0]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL restart_extra_write: got %h want no write", fifo_din[0]); end
        else begin
          want = exp_q.pop_front();
          if (fifo_din[0] !== want) begin n_bad++; $display("FAIL restart_data: got %h want %h", fifo_din[0], want); end
        end
      end
      if (frame_done[0]) ndone++;
      if (!restarted && busy[0] && !rd_enable[0] && rd_addr[0] == AW'(2)) begin
        frame_start[0] = 1'b1; restarted = 1; clr = 1;
      end
    end
    n_cmp += 3;
    if (!restarted) begin n_bad++; $display("FAIL restart_not_reached: got no WAIT_DATA at addr 2 want one"); end
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL restart_missing: got %0d unwritten want 0", exp_q.size()); end
    if (ndone != 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", ndone); end
    n_cmp++;
    if (addr_log0.size() != 7) begin n_bad++; $display("FAIL restart_addr_count: got %0d want 7", addr_log0.size()); end
    else for (int k = 0; k < 7; k++) begin
      n_cmp++;
      if (addr_log0[k] !== want_addr[k]) begin n_bad++; $display("FAIL restart_addr[%0d]: got %0d want %0d", k, addr_log0[k], want_addr[k]); end
    end
  endtask

  task automatic test_frame_wrap();
    int ndone;
    bit clr;
    logic [23:0] want;
    exp_q.delete(); addr_log1.delete();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 3; k++) exp_q.push_back(exp888(mem_word(AW'(100 + k))));
    ndone = 0; clr = 0;
    pulse_start(1);
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (clr) begin frame_start[1] = 1'b0; clr = 0; end
      if (fifo_wr_en[1]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL wrap_extra_write: got %h want no write", fifo_din[1]); end
        else begin
          want = exp_q.pop_front();
          if (fifo_din[1] !== want) begin n_bad++; $display("FAIL wrap_data: got %h want %h", fifo_din[1], want); end
        end
      end
      if (frame_done[1]) begin
        ndone++;
        if (ndone == 1) begin frame_start[1] = 1'b1; clr = 1; end
      end
    end
    n_cmp += 3;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL wrap_missing: got %0d unwritten want 0", exp_q.size()); end
    if (ndone != 2) begin n_bad++; $display("FAIL wrap_done_count: got %0d want 2", ndone); end
    if (addr_log1.size() != 6) begin n_bad++; $display("FAIL wrap_addr_count: got %0d want 6", addr_log1.size()); end
    else for (int k = 0; k < 6; k++) begin
      n_cmp++;
      if (addr_log1[k] !== AW'(100 + (k % 3))) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, addr_log1[k], 100 + (k % 3)); end
    end
  endtask

  task automatic test_timeout();
`ifdef FB_TIMEOUT_EN
    int t, k, nwr;
    logic [23:0] want;
    exp_q.delete();
    exp_q.push_back(24'h000000);
    lat[0] = 20;
    pulse_start(0);
    t = 0;
    while (!(busy[0] && !rd_enable[0]) && t < 100) begin @(negedge clk); t++; end
    enable[0] = 1'b0;
    k = 0;
    while (err[0] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_cmp++;
    if (k != 10) begin n_bad++; $display("FAIL timeout_err_delay: got %0d cycles want 10", k); end
    nwr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fifo_wr_en[0]) begin
        nwr++; n_cmp++;
        if (exp_q.size() == 0) begin n_bad++; $display("FAIL timeout_extra_write: got %h want no write", fifo_din[0]); end
        else begin
          want = exp_q.pop_front();
          if (fifo_din[0] !== want) begin n_bad++; $display("FAIL timeout_data: got %h want %h", fifo_din[0], want); end
        end
      end
    end
    n_cmp += 2;
    if (nwr != 1) begin n_bad++; $display("FAIL timeout_write_count: got %0d want 1", nwr); end
    if (err[0] !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", err[0]); end
    lat[0] = 6;
    enable[0] = 1'b1;
`else
    n_cmp += 2;
    if (err[0] !== 1'b0) begin n_bad++; $display("FAIL err_tied0[0]: got %b want 0", err[0]); end
    if (err[1] !== 1'b0) begin n_bad++; $display("FAIL err_tied0[1]: got %b want 0", err[1]); end
`endif
  endtask

  task automatic test_reset_mid_push();
    int nwr, t, n_req;
    enable[0] = 1'b1; fifo_full[0] = 1'b0;
    pulse_start(0);
    nwr = 0; t = 0;
    while (nwr < 2 && t < 100) begin
      @(negedge clk); t++;
      if (fifo_wr_en[0]) nwr++;
    end
    fifo_full[0] = 1'b1;
    t = 0;
    while (rd_ready[0] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    n_cmp++;
    if (rd_addr[0] !== AW'(2)) begin n_bad++; $display("FAIL rst_setup_addr: got %0d want 2", rd_addr[0]); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 6;
    if (rd_addr[0] !== AW'(0)) begin n_bad++; $display("FAIL rst_async_rd_addr: got %0d want 0", rd_addr[0]); end
    if (fifo_din[0] !== 24'h0) begin n_bad++; $display("FAIL rst_async_fifo_din: got %h want 000000", fifo_din[0]); end
    if (rd_enable[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_rd_enable: got %b want 0", rd_enable[0]); end
    if (fifo_wr_en[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_fifo_wr_en: got %b want 0", fifo_wr_en[0]); end
    if (frame_done[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_frame_done: got %b want 0", frame_done[0]); end
    if (err[0] !== 1'b0) begin n_bad++; $display("FAIL rst_async_err: got %b want 0", err[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    fifo_full[0] = 1'b0;
    n_req = 0; nwr = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_enable[0]) n_req++;
      if (fifo_wr_en[0]) nwr++;
    end
    n_cmp += 2;
    if (n_req != 0) begin n_bad++; $display("FAIL rst_idle_request: got %0d request cycles want 0", n_req); end
    if (nwr != 0) begin n_bad++; $display("FAIL rst_idle_write: got %0d writes want 0", nwr); end
  endtask

  initial begin
    test_reset();
    test_normal_fetch();
    test_full_stall();
    test_mid_read_restart();
    test_frame_wrap();
    test_timeout();
    test_reset_mid_push();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
